// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: FSM states, hex font, widths.
package alu_disp_pkg;

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_HI = 2'd1,
    SHOW_LO = 2'd2,
    GAP     = 2'd3
  } disp_state_e;

  // Active-high segments, bit0 = a ... bit6 = g, indexed by hex digit
  localparam logic [SEG_W-1:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/alu_result_display_if.sv
// Valid/ready result bus from the ALU into the display stage.
interface alu_result_display_if;
  import alu_disp_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to 7-segment decode using the shared font.
module hex_to_seg7
  import alu_disp_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/alu_result_display.sv
// Shows each accepted ALU result as high nibble, low nibble, then blank, each for DWELL_COUNT cycles.
// Optional macro ALU_DISP_REPEAT_EN: loop the held value forever and accept new data during GAP.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter logic [CNT_W-1:0] DWELL_COUNT = 24'd10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_result_display_if.slave   in_if,
  output logic [SEG_W-1:0]      seg_out,
  output logic                  dp_out,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = DWELL_COUNT - CNT_W'(1);

  disp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              busy_q, busy_d;

  logic              ready;
  logic              accept;
  logic              dwell_done;
  logic [NIB_W-1:0]  nib_sel;
  logic [SEG_W-1:0]  font_seg;

`ifdef ALU_DISP_REPEAT_EN
  assign ready = (state_q == IDLE) || (state_q == GAP);
`else
  assign ready = (state_q == IDLE);
`endif

  assign in_if.in_ready = ready;
  assign accept         = in_if.in_valid && ready;
  assign dwell_done     = (cnt_q == DWELL_LAST);

  hex_to_seg7 u_font (
    .nibble_i (nib_sel),
    .seg_o    (font_seg)
  );

  // Next state, counter and hold register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = in_if.in_data;
          cnt_d   = '0;
          state_d = SHOW_HI;
        end
      end
      SHOW_HI: begin
        if (dwell_done) begin
          cnt_d   = '0;
          state_d = SHOW_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHOW_LO: begin
        if (dwell_done) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
`ifdef ALU_DISP_REPEAT_EN
        // A new result preempts the dwell expiry
        if (accept) begin
          hold_d  = in_if.in_data;
          cnt_d   = '0;
          state_d = SHOW_HI;
        end else if (dwell_done) begin
          cnt_d   = '0;
          state_d = SHOW_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        if (dwell_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs follow the next state so they change on the same edge as the state
  always_comb begin
    nib_sel = hold_d[NIB_W-1:0];
    seg_d   = '0;
    dp_d    = 1'b0;
    busy_d  = (state_d != IDLE);
    if (state_d == SHOW_HI) begin
      nib_sel = hold_d[DATA_W-1:NIB_W];
      seg_d   = font_seg;
      dp_d    = 1'b1;
    end else if (state_d == SHOW_LO) begin
      seg_d = font_seg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      busy_q  <= busy_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with DWELL_COUNT = 4.
module tb_alu_result_display;
  import alu_disp_pkg::*;

  localparam int unsigned DW = 4;

  logic       clk;
  logic       reset;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       busy;

  alu_result_display_if bus ();

  alu_result_display #(.DWELL_COUNT(24'd4)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_if   (bus.slave),
    .seg_out (seg_out),
    .dp_out  (dp_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [6:0] font [16];

  typedef struct {
    logic [7:0] data;
    logic [6:0] hi;
    logic [6:0] lo;
  } vec_t;
  vec_t vecs [10];

  time        hs_time [$];
  logic [7:0] hs_data [$];

  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      hs_time.push_back($time);
      hs_data.push_back(bus.in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One full handshake + HI/LO/GAP sequence, checked every cycle, ending in IDLE
  task automatic run_seq(input string tag, input logic [7:0] d, input logic [6:0] hi, input logic [6:0] lo);
    logic [6:0] exp_seg;
    logic       exp_dp;
    @(negedge clk);
    chk({tag, "_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    for (int i = 0; i < 3 * int'(DW); i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      exp_seg = (i < int'(DW)) ? hi : (i < 2 * int'(DW)) ? lo : 7'h00;
      exp_dp  = (i < int'(DW));
      chk({tag, "_seg"},   32'(seg_out),      32'(exp_seg));
      chk({tag, "_dp"},    32'(dp_out),       32'(exp_dp));
      chk({tag, "_busy"},  32'(busy),         32'd1);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_end_seg"},   32'(seg_out),      32'd0);
    chk({tag, "_end_dp"},    32'(dp_out),       32'd0);
    chk({tag, "_end_busy"},  32'(busy),         32'd0);
    chk({tag, "_end_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vecs[0] = '{8'hA5, 7'h77, 7'h6D};
    vecs[1] = '{8'h00, 7'h3F, 7'h3F};
    vecs[2] = '{8'hFF, 7'h71, 7'h71};
    vecs[3] = '{8'h12, 7'h06, 7'h5B};
    vecs[4] = '{8'h3C, 7'h4F, 7'h39};
    vecs[5] = '{8'hF0, 7'h71, 7'h3F};
    vecs[6] = '{8'h7E, 7'h07, 7'h79};
    vecs[7] = '{8'h81, 7'h7F, 7'h06};
    vecs[8] = '{8'h9B, 7'h6F, 7'h7C};
    vecs[9] = '{8'hD4, 7'h5E, 7'h66};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_seg",   32'(seg_out),      32'd0);
    chk("idle_dp",    32'(dp_out),       32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_busy",  32'(busy),         32'd0);

`ifndef ALU_DISP_REPEAT_EN
    for (int v = 0; v < 10; v++) begin
      run_seq($sformatf("vec%0d", v), vecs[v].data, vecs[v].hi, vecs[v].lo);
    end

    // Back-to-back with in_valid held high; data changes after the first handshake
    hs_time.delete();
    hs_data.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    @(posedge clk); #1;
    chk("b2b_hi_seg", 32'(seg_out), 32'h4F);
    chk("b2b_hi_dp",  32'(dp_out),  32'd1);
    @(negedge clk);
    bus.in_data = 8'hF0;
    repeat (DW) @(posedge clk);
    #1;
    chk("b2b_lo_seg",   32'(seg_out),      32'h39);
    chk("b2b_lo_ready", 32'(bus.in_ready), 32'd0);
    for (int n = 0; n < 40 && hs_time.size() < 2; n++) begin
      @(posedge clk); #1;
    end
    chk("b2b_hs_count", 32'(hs_time.size()), 32'd2);
    if (hs_time.size() >= 2) begin
      chk("b2b_spacing", 32'((hs_time[1] - hs_time[0]) / 10), 32'd13);
      chk("b2b_data0",   32'(hs_data[0]), 32'h3C);
      chk("b2b_data1",   32'(hs_data[1]), 32'hF0);
      chk("b2b2_hi_seg", 32'(seg_out),    32'h71);
      chk("b2b2_hi_dp",  32'(dp_out),     32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3 * DW) @(posedge clk);
    #1;
    chk("b2b_end_ready", 32'(bus.in_ready), 32'd1);
    chk("b2b_end_busy",  32'(busy),         32'd0);

    // Asynchronous reset two cycles into SHOW_LO
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h12;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (DW + 1) @(posedge clk);
    #1;
    chk("rst_pre_seg", 32'(seg_out), 32'h5B);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_seg",   32'(seg_out),     32'd0);
    chk("rst_dp",    32'(dp_out),      32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_post_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_post_seg",   32'(seg_out),      32'd0);

    // Full sweep against the bench font table
    for (int i = 0; i < 256; i++) begin
      run_seq($sformatf("sweep%02h", i), 8'(i), font[i / 16], font[i % 16]);
    end
`else
    // Repeat mode: held value loops; handshake in GAP restarts at SHOW_HI
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h81;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      case ((i / int'(DW)) % 3)
        0: begin
          chk("rep_hi_seg", 32'(seg_out), 32'h7F);
          chk("rep_hi_dp",  32'(dp_out),  32'd1);
        end
        1: begin
          chk("rep_lo_seg", 32'(seg_out), 32'h06);
          chk("rep_lo_dp",  32'(dp_out),  32'd0);
        end
        default: begin
          chk("rep_gap_seg",   32'(seg_out),      32'd0);
          chk("rep_gap_ready", 32'(bus.in_ready), 32'd1);
        end
      endcase
      chk("rep_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7E;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rep_new_seg", 32'(seg_out), 32'h07);
    chk("rep_new_dp",  32'(dp_out),  32'd1);
    repeat (DW) @(posedge clk);
    #1;
    chk("rep_new_lo_seg", 32'(seg_out), 32'h79);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
